// File: rtl/if_id_hazard_ctrl.sv
// IF/ID sequencing controller: load-use stalls, ID branch flushes and I-miss waits.
// Optional performance counters are built when IF_ID_HAZARD_CTRL_PERF_EN is defined.
module if_id_hazard_ctrl #(
  parameter int unsigned MISS_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        ID_EX_MemRead_i,
  input  logic [4:0]  ID_EX_RegRt_i,
  input  logic [4:0]  IF_ID_RegRs_i,
  input  logic [4:0]  IF_ID_RegRt_i,
  input  logic        branch_taken_i,
  input  logic        imem_ready_i,
  output logic        PC_write_o,
  output logic        IF_ID_write_o,
  output logic        IF_ID_flush_o,
  output logic        ID_EX_bubble_o,
  output logic [1:0]  state_o,
  output logic        err_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] miss_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    IMISS = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(MISS_TIMEOUT);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0] wait_cnt_nxt_s;
  logic             err_r;
  logic             err_nxt_s;
  logic             hz_s;
  logic             pc_write_s;
  logic             ifid_write_s;
  logic             ifid_flush_s;
  logic             bubble_s;

  function automatic logic load_use(input logic       mem_read,
                                    input logic [4:0] ex_rt,
                                    input logic [4:0] id_rs,
                                    input logic [4:0] id_rt);
    return mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

  assign hz_s = load_use(ID_EX_MemRead_i, ID_EX_RegRt_i, IF_ID_RegRs_i, IF_ID_RegRt_i);

  // Next-state, miss counter and Mealy pipeline controls
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    pc_write_s     = 1'b0;
    ifid_write_s   = 1'b0;
    ifid_flush_s   = 1'b0;
    bubble_s       = 1'b0;
    case (state_r)
      IDLE: begin
        bubble_s = 1'b1;
        if (start_i) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (hz_s) begin
          bubble_s = 1'b1;
        end else if (branch_taken_i) begin
          pc_write_s   = 1'b1;
          ifid_write_s = 1'b1;
          ifid_flush_s = 1'b1;
        end else if (!imem_ready_i) begin
          // Push a nop into ID while the fetch is outstanding
          ifid_write_s   = 1'b1;
          ifid_flush_s   = 1'b1;
          state_nxt_s    = IMISS;
          wait_cnt_nxt_s = CNT_ONE;
        end else begin
          pc_write_s   = 1'b1;
          ifid_write_s = 1'b1;
        end
      end
      IMISS: begin
        if (imem_ready_i) begin
          pc_write_s     = 1'b1;
          ifid_write_s   = 1'b1;
          state_nxt_s    = RUN;
          wait_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
          ifid_write_s = 1'b1;
          ifid_flush_s = 1'b1;
          if (wait_cnt_r == CNT_MAX) begin
            wait_cnt_nxt_s = wait_cnt_r;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r + CNT_ONE;
          end
        end
      end
      default: begin
        bubble_s       = 1'b1;
        state_nxt_s    = IDLE;
        wait_cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Sticky timeout flag: sets on the edge the miss wait reaches the limit
  always_comb begin
    if ((state_nxt_s == IMISS) && (wait_cnt_nxt_s == CNT_TIMEOUT)) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // State, miss counter and error flag registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r    <= IDLE;
      wait_cnt_r <= {CNT_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

  assign PC_write_o     = pc_write_s;
  assign IF_ID_write_o  = ifid_write_s;
  assign IF_ID_flush_o  = ifid_flush_s;
  assign ID_EX_bubble_o = bubble_s;
  assign state_o        = state_r;
  assign err_o          = err_r;

`ifdef IF_ID_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;
  logic [31:0] miss_cnt_r;

  // Event counters; they wrap naturally at 2^32
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
      miss_cnt_r  <= 32'd0;
    end else begin
      if ((state_r == RUN) && hz_s) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if ((state_r == RUN) && !hz_s && branch_taken_i) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
      if (state_r == IMISS) begin
        miss_cnt_r <= miss_cnt_r + 32'd1;
      end else begin
        miss_cnt_r <= miss_cnt_r;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_r;
  assign flush_cnt_o = flush_cnt_r;
  assign miss_cnt_o  = miss_cnt_r;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
  assign miss_cnt_o  = 32'd0;
`endif

endmodule
